// File: rtl/sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Sequences an asynchronous SRAM (addr, bidirectional data,
//            active-low ce_n/oe_n/we_n) for one clocked host. Converts
//            single-cycle read/write requests into ordered strobe sequences
//            with programmable wait states and returns read data with a
//            one-cycle valid pulse.
// Options  : SRAM_CTRL_WRITE_VERIFY_EN - read back every write and flag a
//            mismatch on wr_err together with done.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  done,
   output logic                  wr_err,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   // Wait-state counter reload value; WAIT_CYCLES is limited to 0..15.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_SETUP  = 3'd1,
      WR_PULSE  = 3'd2,
      WR_HOLD   = 3'd3,
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      VF_READ   = 3'd5,
`endif
      RD_ACCESS = 3'd4
   } state_t;

   state_t                state;
   logic [3:0]            wcnt;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  drive_en;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   logic                  vf_err;
   assign wr_err = vf_err;
`else
   assign wr_err = 1'b0;
`endif

   // The data bus is driven only from a flop, so it releases with the strobes
   // on reset and is never enabled in a state that also asserts oe_n.
   assign sram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

   // Single FSM: every host-visible and SRAM-visible output is a flop so the
   // strobes are glitch-free and fall back to inactive asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= 4'd0;
         wdata_q   <= '0;
         drive_en  <= 1'b0;
         ready     <= 1'b1;
         rdata     <= '0;
         rvalid    <= 1'b0;
         done      <= 1'b0;
         sram_addr <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
         vf_err    <= 1'b0;
`endif
      end else begin
         // Completion flags are single-cycle pulses.
         rvalid <= 1'b0;
         done   <= 1'b0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
         vf_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req) begin
                  // Address is only loaded here, i.e. while we_n is high.
                  sram_addr <= addr_in;
                  wdata_q   <= wdata;
                  ready     <= 1'b0;
                  sram_ce_n <= 1'b0;
                  if (wr) begin
                     drive_en <= 1'b1;
                     state    <= WR_SETUP;
                  end else begin
                     sram_oe_n <= 1'b0;
                     wcnt      <= WAIT_LOAD;
                     state     <= RD_ACCESS;
                  end
               end
            end

            WR_SETUP: begin
               sram_we_n <= 1'b0;
               wcnt      <= WAIT_LOAD;
               state     <= WR_PULSE;
            end

            WR_PULSE: begin
               if (wcnt == 4'd0) begin
                  sram_we_n <= 1'b1;
                  state     <= WR_HOLD;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end

            WR_HOLD: begin
               drive_en <= 1'b0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
               // Turn the bus around and read the same address back.
               sram_oe_n <= 1'b0;
               wcnt      <= WAIT_LOAD;
               state     <= VF_READ;
`else
               sram_ce_n <= 1'b1;
               ready     <= 1'b1;
               done      <= 1'b1;
               state     <= IDLE;
`endif
            end

            RD_ACCESS: begin
               if (wcnt == 4'd0) begin
                  rdata     <= sram_data;
                  rvalid    <= 1'b1;
                  ready     <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            VF_READ: begin
               if (wcnt == 4'd0) begin
                  // Read-back goes only to the compare, never to rdata.
                  vf_err    <= (sram_data != wdata_q);
                  done      <= 1'b1;
                  ready     <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
`endif

            default: begin
               drive_en  <= 1'b0;
               ready     <= 1'b1;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_we_n <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Scoreboard bench for sram_ctrl with a behavioural SRAM model.
//            Honours SRAM_CTRL_WRITE_VERIFY_EN for latency and wr_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

   localparam int W  = 3;
   localparam int AW = 8;
   localparam int DW = 16;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
   localparam int WR_LAT = 2 * W + 4;
   localparam bit VF     = 1'b1;
`else
   localparam int WR_LAT = W + 3;
   localparam bit VF     = 1'b0;
`endif
   localparam int RD_LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req, wr;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] wdata;
   logic          ready, rvalid, done, wr_err;
   logic [DW-1:0] rdata;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_data;
   logic          sram_ce_n, sram_oe_n, sram_we_n;

   sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in),
      .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid),
      .done(done), .wr_err(wr_err), .sram_addr(sram_addr),
      .sram_data(sram_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM: drives on ce_n&oe_n low, writes on we_n rise.
   logic [DW-1:0] mem [256];
   bit            stuck_en = 1'b0;
   assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : {DW{1'bz}};
   always @(posedge sram_we_n)
      if (!sram_ce_n)
         mem[sram_addr] <= stuck_en ? (sram_data & 16'hFFFE) : sram_data;

   typedef struct {
      bit            is_wr;
      logic [DW-1:0] data;
      bit            err;
      int            ts;
   } exp_t;
   exp_t q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every rvalid/done and checks strobe timing.
   int   we_run = 0;
   int   oe_run = 0;
   exp_t e;
   always @(negedge clk) begin
      if (rst) begin
         we_run = 0;
         oe_run = 0;
      end else begin
         chk("strobe_excl", {31'b0, (!sram_oe_n && !sram_we_n)}, 32'd0);
         if (!done) chk("wr_err_without_done", {31'b0, wr_err}, 32'd0);
         if (rvalid || done) begin
            chk("resp_pending", {31'b0, (q.size() != 0)}, 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("resp_kind", {31'b0, done}, {31'b0, e.is_wr});
               chk("resp_time", cyc, e.ts);
               chk("ready_with_resp", {31'b0, ready}, 32'd1);
               if (e.is_wr) chk("wr_err", {31'b0, wr_err}, {31'b0, e.err});
               else         chk("rdata", {16'b0, rdata}, {16'b0, e.data});
            end
         end
         if (!sram_we_n) we_run++;
         else if (we_run != 0) begin
            chk("we_n_low_len", we_run, W + 1);
            we_run = 0;
         end
         if (!sram_oe_n) oe_run++;
         else if (oe_run != 0) begin
            chk("oe_n_low_len", oe_run, W + 1);
            oe_run = 0;
         end
      end
   end

   // Issue one request on the next ready cycle; optionally keep req high
   // for 'hold' extra edges while the controller is busy.
   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input bit exp_err,
                        input bit push, input int hold);
      int t = 0;
      @(negedge clk);
      while (!ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_timeout", {31'b0, ready}, 32'd1);
      req     = 1'b1;
      wr      = w;
      addr_in = a;
      wdata   = d;
      @(posedge clk);
      #1;
      if (push) q.push_back('{w, exp_rd, exp_err, cyc + (w ? WR_LAT : RD_LAT)});
      if (hold > 0) begin
         chk("busy_after_accept", {31'b0, ready}, 32'd0);
         repeat (hold) @(posedge clk);
         #1;
      end
      req = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain", q.size(), 32'd0);
   endtask

   initial begin
      int t;
      logic [DW-1:0] d;
      req = 1'b0; wr = 1'b0; addr_in = '0; wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_ready",  {31'b0, ready},  32'd1);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_done",   {31'b0, done},   32'd0);
      chk("rst_wr_err", {31'b0, wr_err}, 32'd0);
      chk("rst_rdata",  {16'b0, rdata},  32'd0);
      chk("rst_addr",   {24'b0, sram_addr}, 32'd0);
      chk("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
      rst = 1'b0;

      // Basic write/read pairs
      issue(1'b1, 8'h10, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 0);
      issue(1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0, 1'b1, 0);
      issue(1'b1, 8'h11, 16'h5A3C, 16'h0000, 1'b0, 1'b1, 0);
      issue(1'b0, 8'h11, 16'h0000, 16'h5A3C, 1'b0, 1'b1, 0);
      issue(1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0, 1'b1, 0);

      // Back-to-back writes 0x00..0x0F; first one holds req through busy
      for (int i = 0; i < 16; i++) begin
         d = 16'hC300 | 16'(i);
         issue(1'b1, 8'(i), d, 16'h0000, 1'b0, 1'b1, (i == 0) ? W + 2 : 0);
      end
      for (int i = 0; i < 16; i++) begin
         d = 16'hC300 | 16'(i);
         issue(1'b0, 8'(i), 16'h0000, d, 1'b0, 1'b1, 0);
      end
      drain();

      // Reset during WR_PULSE abandons the write
      issue(1'b1, 8'h20, 16'h1234, 16'h0000, 1'b0, 1'b1, 0);
      drain();
      issue(1'b1, 8'h20, 16'hDEAD, 16'h0000, 1'b0, 1'b0, 0);
      t = 0;
      while (sram_we_n && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("reach_wr_pulse", {31'b0, sram_we_n}, 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("abort_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
      chk("abort_bus_released", {31'b0, (sram_data === 16'hDEAD)}, 32'd0);
      chk("abort_ready", {31'b0, ready}, 32'd1);
      chk("abort_no_done", {31'b0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 8'h20, 16'h0000, 16'h1234, 1'b0, 1'b1, 0);
      drain();

      // Write verify against a model with bit 0 stuck at 0
      stuck_en = 1'b1;
      issue(1'b1, 8'h30, 16'h0001, 16'h0000, VF, 1'b1, 0);
      issue(1'b1, 8'h31, 16'h0002, 16'h0000, 1'b0, 1'b1, 0);
      drain();
      stuck_en = 1'b0;
      issue(1'b0, 8'h31, 16'h0000, 16'h0002, 1'b0, 1'b1, 0);
      drain();

      repeat (3) @(negedge clk);
      chk("final_queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous controller that sequences the asynchronous SRAM chip (`addr`, bidirectional `data`, active-low `ce_n`/`oe_n`/`we_n`) on behalf of one clocked host. It converts single-cycle host read/write requests into correctly ordered strobe sequences with programmable wait states, owns the tri-state data bus, and returns read data with a valid pulse. It sits between the system logic and the `sram_memory` instance, and is the only driver of the SRAM pins.

## Interface
- `ADDR_WIDTH`, 8: address width, matches the SRAM.
- `DATA_WIDTH`, 16: data width, matches the SRAM.
- `WAIT_CYCLES`, 0: extra cycles added to each access phase, range 0..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only while `ready`=1.
- `wr`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr_in`  in  ADDR_WIDTH  request address.
- `wdata`  in  DATA_WIDTH  write data.
- `ready`  out  1  controller idle; will accept `req` this cycle.
- `rdata`  out  DATA_WIDTH  last read data; holds until the next read completes.
- `rvalid`  out  1  one-cycle pulse when `rdata` is updated.
- `done`  out  1  one-cycle pulse when a write completes.
- `wr_err`  out  1  one-cycle pulse with `done` on a verify mismatch. Constant 0 without the macro.
- `sram_addr`  out  ADDR_WIDTH  to SRAM `addr`.
- `sram_data`  inout  DATA_WIDTH  to SRAM `data`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes; registered, glitch-free.

## Operation
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, plus VF_READ with the macro.
- IDLE:
  - `ready`=1, all strobes 1, `sram_data` released (Z).
  - On `req`: latch `addr_in`, `wr` and `wdata`, then go to WR_SETUP (`wr`=1) or RD_ACCESS (`wr`=0).
- WR_SETUP, 1 cycle: `ce_n`=0, `we_n`=1, `oe_n`=1. Address and data are driven.
- WR_PULSE, WAIT_CYCLES+1 cycles: `we_n`=0. Address and data are stable.
- WR_HOLD, 1 cycle: `we_n`=1, `ce_n`=0. Data is still driven.
- After WR_HOLD, the FSM goes to IDLE and asserts `done`.
- RD_ACCESS, WAIT_CYCLES+1 cycles:
  - `ce_n`=0, `oe_n`=0, `we_n`=1, bus released.
  - `rdata` captures `sram_data` on the edge leaving the state.
  - The FSM then goes to IDLE and asserts `rvalid`.
- The controller drives `sram_data` only in WR_SETUP, WR_PULSE and WR_HOLD. It never drives while `oe_n`=0.
- `oe_n` and `we_n` are never both 0.
- A wait-state counter loads WAIT_CYCLES on state entry and counts down. It exits on 0.
- `req` while `ready`=0 is ignored, not queued.
- `ready` is asserted in the same IDLE cycle as `done`/`rvalid`, so back-to-back accept is allowed.
- Address changes only while `we_n`=1.

## Timing
Let W = WAIT_CYCLES, with a request accepted at edge N.
- Write:
  - `we_n` is low for exactly W+1 cycles.
  - `done`=1 and `ready`=1 in the cycle after edge N+W+3.
  - With the macro, this becomes edge N+2W+4.
- Read: `rvalid`=1 and `rdata` valid in the cycle after edge N+W+1.
- Reset values:
  - `ready`=1, `rvalid`=0, `done`=0, `wr_err`=0, `rdata`=0, `sram_addr`=0.
  - All strobes 1, bus Z, state IDLE.
- Reset mid-operation:
  - Strobes deassert and the bus releases immediately, without waiting for a clock.
  - The in-flight access is abandoned, with no `done`/`rvalid`.

## Configuration
- `SRAM_CTRL_WRITE_VERIFY_EN` defined:
  - After WR_HOLD, the FSM enters VF_READ, which is a read of the same address for W+1 cycles with the RD_ACCESS strobe pattern.
  - The read-back is compared to the latched `wdata`.
  - `done` pulses after VF_READ. `wr_err`=1 in the same cycle if the values differ.
  - `rdata` and `rvalid` are unaffected.
- Undefined: there is no VF_READ state and `wr_err` is tied to 0.

## Test plan
- W=0: write 0xA5A5 to 0x10, then read 0x10 → `done` 3 cycles after accept; `rvalid` 1 cycle after read accept with `rdata`=0xA5A5.
- W=3: write then read → `we_n` low exactly 4 cycles; `oe_n` low exactly 4 cycles; no cycle with controller driving while `oe_n`=0.
- Back-to-back: writes to 0x00..0x0F issued on every `ready`, then reads → all data match; `req` held while busy produces no extra access.
- Reset asserted in WR_PULSE → strobes 1 and bus Z before the next edge; no `done`; a subsequent read of 0x20 returns the prior contents.
- Macro on, bench model with bit 0 stuck at 0: write 0x0001 → `wr_err`=1 with `done`; write 0x0002 → `wr_err`=0.
